led_status_gen: RTL and testbench
=================================

Name: led_status_gen

Overview:
- Per-port LED status generator for 8 ports. Sits directly upstream of the 8-port LED output driver.
- Produces the shared blink square wave, debounced active-low link flags and pulse-stretched active-low activity flags that the driver turns into tri-stated LED pins.
- Inputs come from PHY/MAC status: link level is asynchronous; activity pulses are single-cycle and synchronous to clk.

Parameters:
- BLINK_DIV, 24'd6250000, clk cycles per blink half-period; tick period; legal range >= 2.
- STRETCH_TICKS, 4'd3, ticks an activity indication is held after the last pulse; legal range >= 1.
- LINK_DEBOUNCE, 4'd8, consecutive ticks a changed link level must be stable before it is accepted; legal range >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- link_up_in  input  8  raw link status per port, 1 = up, asynchronous to clk
- act_pulse_in  input  8  activity strobe per port, 1-cycle pulse, synchronous to clk
- blink  output  1  blink square wave to LED driver
- link  output  8  debounced link per port, active-low (0 = link up, LED enabled)
- act  output  8  stretched activity per port, active-low (0 = blink LED)

Behaviour:
- Reset (async assert; deassert sampled on clk): blink=0, link=8'hFF, act=8'hFF. Prescaler, stretch counters, debounce counters and sync flops all clear; sync flops clear to 0.
- Reset asserted mid-operation forces all outputs to their reset values immediately, with no clock edge required.
- Prescaler:
  - Counts 0..BLINK_DIV-1 and wraps to 0.
  - Internal tick is 1 for the single cycle where count == BLINK_DIV-1.
  - First tick falls in cycle BLINK_DIV after reset release.
  - blink is registered and toggles on the edge following each tick. Period = 2*BLINK_DIV cycles, 50% duty.
- Link path, per port n:
  - link_up_in[n] passes through a 2-flop synchronizer to produce s[n].
  - A debounced state d[n] (reset 0) and a debounce counter c[n] are kept.
  - If s[n] == d[n]: c[n] clears every cycle.
  - Else, on each tick, c[n] increments. When a tick occurs with c[n] == LINK_DEBOUNCE-1, d[n] flips and c[n] clears.
  - Any glitch back to d[n] before acceptance restarts the count.
  - link[n] = ~d[n], registered.
- Activity path, per port n:
  - A stretch counter a[n] is kept.
  - act_pulse_in[n]=1 loads a[n] with STRETCH_TICKS. This is retriggerable and reloads even when nonzero. A pulse coincident with a tick reloads; load wins over decrement.
  - Otherwise a tick with a[n] != 0 decrements a[n].
  - act[n] = ~(a[n] != 0), registered, so act[n] falls 1 cycle after the pulse cycle.
  - Held-low duration is between (STRETCH_TICKS-1)*BLINK_DIV+1 and STRETCH_TICKS*BLINK_DIV cycles after the last pulse.
  - While d[n] == 0 (link down), a[n] is held at 0 and pulses are ignored, so act[n] = 1.
  - When the link comes up, activity starts from 0.
- Ports are fully independent; simultaneous pulses or link changes on several ports need no arbitration.
- Counter widths are sized to their parameters; no counter wraps past its bound.

Test Plan:
- Bench parameters: BLINK_DIV=4, STRETCH_TICKS=3, LINK_DEBOUNCE=2.
- Reset release, no inputs -> blink=0 for cycles 0-4, 1 for cycles 5-8, 0 for 9-12 (period 8); link=8'hFF, act=8'hFF throughout.
- link_up_in=8'h01 held steady from cycle 0 -> link[0] goes 0 after sync plus 2 ticks (by cycle 12); link[7:1] stay 1. Then drop link_up_in[0] for 3 cycles and restore -> link[0] never returns to 1.
- Port 0 link up; one pulse act_pulse_in[0] at cycle 20 -> act[0]=0 from cycle 21 until 1 cycle after the 3rd tick following cycle 20; act[7:1]=1.
- Port 0 link up; second pulse arriving while act[0] is low, including one coincident with a tick -> counter reloads to 3 and act[0] stays low continuously for a further 2-3 ticks after the second pulse.
- act_pulse_in=8'hFF with link down on all ports -> act stays 8'hFF. Assert rst mid-stretch with links up -> outputs immediately return to blink=0, link=8'hFF, act=8'hFF.

Source files
------------

// File: rtl/led_status_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_status_gen
// Purpose  : Per-port LED status generator for an 8-port LED output driver.
//            Produces a shared blink square wave, debounced active-low link
//            flags and pulse-stretched active-low activity flags.
// Ports    : clk          - system clock
//            rst          - asynchronous, active-high reset
//            link_up_in   - raw link level per port (1 = up), async to clk
//            act_pulse_in - 1-cycle activity strobe per port, sync to clk
//            blink        - blink square wave, period 2*BLINK_DIV cycles
//            link         - debounced link per port, active-low
//            act          - stretched activity per port, active-low
// Revision : 1.0 - initial release
// ============================================================================
module led_status_gen #(
  parameter logic [23:0] BLINK_DIV     = 24'd6250000,
  parameter logic [3:0]  STRETCH_TICKS = 4'd3,
  parameter logic [3:0]  LINK_DEBOUNCE = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] link_up_in,
  input  logic [7:0] act_pulse_in,
  output logic       blink,
  output logic [7:0] link,
  output logic [7:0] act
);

  localparam int PW = $clog2(BLINK_DIV);
  localparam int AW = $clog2(STRETCH_TICKS + 1);
  localparam int CW = (LINK_DEBOUNCE > 4'd1) ? $clog2(LINK_DEBOUNCE) : 1;

  localparam logic [PW-1:0] PRE_LAST     = PW'(BLINK_DIV - 24'd1);
  localparam logic [AW-1:0] STRETCH_LOAD = AW'(STRETCH_TICKS);
  localparam logic [CW-1:0] DEB_LAST     = CW'(LINK_DEBOUNCE - 4'd1);

  // --------------------------------------------------------------------------
  // Prescaler: one tick per blink half-period, shared by all ports
  // --------------------------------------------------------------------------
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      blink   <= 1'b0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        blink   <= ~blink;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-port link debounce and activity stretch
  // --------------------------------------------------------------------------
  genvar n;
  generate
    for (n = 0; n < 8; n++) begin : g_port
      logic [1:0]    sync;
      logic          deb;
      logic          deb_nxt;
      logic [CW-1:0] dcnt;
      logic [CW-1:0] dcnt_nxt;
      logic [AW-1:0] acnt;
      logic [AW-1:0] acnt_nxt;
      logic          link_q;
      logic          act_q;

      always_comb begin
        deb_nxt  = deb;
        dcnt_nxt = dcnt;
        acnt_nxt = acnt;

        // Any return to the accepted level restarts the stability count.
        if (sync[1] == deb) begin
          dcnt_nxt = '0;
        end else if (tick) begin
          if (dcnt == DEB_LAST) begin
            deb_nxt  = ~deb;
            dcnt_nxt = '0;
          end else begin
            dcnt_nxt = dcnt + CW'(1);
          end
        end

        // Link down forces the stretch idle; a pulse reload beats a tick.
        if (!deb) begin
          acnt_nxt = '0;
        end else if (act_pulse_in[n]) begin
          acnt_nxt = STRETCH_LOAD;
        end else if (tick && (acnt != '0)) begin
          acnt_nxt = acnt - AW'(1);
        end
      end

      // The output flops take the next-state decode so act falls in the
      // cycle right after the pulse instead of one cycle later.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync   <= 2'b00;
          deb    <= 1'b0;
          dcnt   <= '0;
          acnt   <= '0;
          link_q <= 1'b1;
          act_q  <= 1'b1;
        end else begin
          sync   <= {sync[0], link_up_in[n]};
          deb    <= deb_nxt;
          dcnt   <= dcnt_nxt;
          acnt   <= acnt_nxt;
          link_q <= ~deb_nxt;
          act_q  <= (acnt_nxt == '0);
        end
      end

      assign link[n] = link_q;
      assign act[n]  = act_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_status_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_led_status_gen
// Purpose  : Self-checking bench for led_status_gen with BLINK_DIV=4,
//            STRETCH_TICKS=3, LINK_DEBOUNCE=2. Cycle 1 is the first cycle
//            after reset release (prescaler count 0 there); outputs are
//            sampled on the falling edge of each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_status_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] link_up_in = 8'h00;
  logic [7:0] act_pulse_in = 8'h00;
  logic       blink;
  logic [7:0] link;
  logic [7:0] act;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_status_gen #(
    .BLINK_DIV    (24'd4),
    .STRETCH_TICKS(4'd3),
    .LINK_DEBOUNCE(4'd2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .link_up_in  (link_up_in),
    .act_pulse_in(act_pulse_in),
    .blink       (blink),
    .link        (link),
    .act         (act)
  );

  typedef struct {
    int         cyc;
    logic [7:0] lnk;
    logic [7:0] pulse;
    logic       eb;
    logic [7:0] el;
    logic [7:0] ea;
  } vec_t;

  vec_t tab [28];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reset is held across one edge, its values checked, then released just
  // after the next edge so that the following cycle is cycle 1.
  task automatic do_reset();
    rst = 1'b1;
    act_pulse_in = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check("reset_blink", {7'd0, blink}, 8'h00);
    check("reset_link", link, 8'hFF);
    check("reset_act", act, 8'hFF);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cur;
    int wait_n;

    //            cyc  lnk    pulse  eb    el     ea
    tab[0]  = '{   1, 8'h01, 8'h00, 1'b0, 8'hFF, 8'hFF};
    tab[1]  = '{   4, 8'h01, 8'h00, 1'b0, 8'hFF, 8'hFF};
    tab[2]  = '{   5, 8'h01, 8'h00, 1'b1, 8'hFF, 8'hFF};
    tab[3]  = '{   8, 8'h01, 8'h00, 1'b1, 8'hFF, 8'hFF};
    tab[4]  = '{   9, 8'h01, 8'h00, 1'b0, 8'hFE, 8'hFF};
    tab[5]  = '{  12, 8'h01, 8'h00, 1'b0, 8'hFE, 8'hFF};
    tab[6]  = '{  13, 8'h01, 8'h00, 1'b1, 8'hFE, 8'hFF};
    // three-cycle drop of port 0 link; must not be accepted
    tab[7]  = '{  14, 8'h00, 8'h00, 1'b1, 8'hFE, 8'hFF};
    tab[8]  = '{  15, 8'h00, 8'h00, 1'b1, 8'hFE, 8'hFF};
    tab[9]  = '{  16, 8'h00, 8'h00, 1'b1, 8'hFE, 8'hFF};
    tab[10] = '{  17, 8'h01, 8'h00, 1'b0, 8'hFE, 8'hFF};
    tab[11] = '{  18, 8'h01, 8'h00, 1'b0, 8'hFE, 8'hFF};
    tab[12] = '{  19, 8'h01, 8'h00, 1'b0, 8'hFE, 8'hFF};
    // single pulse: act low 21..32
    tab[13] = '{  20, 8'h01, 8'h01, 1'b0, 8'hFE, 8'hFF};
    tab[14] = '{  21, 8'h01, 8'h00, 1'b1, 8'hFE, 8'hFE};
    tab[15] = '{  24, 8'h01, 8'h00, 1'b1, 8'hFE, 8'hFE};
    tab[16] = '{  25, 8'h01, 8'h00, 1'b0, 8'hFE, 8'hFE};
    tab[17] = '{  32, 8'h01, 8'h00, 1'b1, 8'hFE, 8'hFE};
    tab[18] = '{  33, 8'h01, 8'h00, 1'b0, 8'hFE, 8'hFF};
    // pulses on tick cycles 36 and 44, off-tick at 50: act low 37..60
    tab[19] = '{  36, 8'h01, 8'h01, 1'b0, 8'hFE, 8'hFF};
    tab[20] = '{  37, 8'h01, 8'h00, 1'b1, 8'hFE, 8'hFE};
    tab[21] = '{  44, 8'h01, 8'h01, 1'b0, 8'hFE, 8'hFE};
    tab[22] = '{  48, 8'h01, 8'h00, 1'b1, 8'hFE, 8'hFE};
    tab[23] = '{  49, 8'h01, 8'h00, 1'b0, 8'hFE, 8'hFE};
    tab[24] = '{  50, 8'h01, 8'h01, 1'b0, 8'hFE, 8'hFE};
    tab[25] = '{  56, 8'h01, 8'h00, 1'b1, 8'hFE, 8'hFE};
    tab[26] = '{  60, 8'h01, 8'h00, 1'b0, 8'hFE, 8'hFE};
    tab[27] = '{  61, 8'h01, 8'h00, 1'b1, 8'hFE, 8'hFF};

    // ---- table-driven run: port 0 link up from reset ----
    link_up_in = 8'h01;
    do_reset();
    cur = 1;
    for (int i = 0; i < 28; i++) begin
      while (cur < tab[i].cyc) begin
        @(posedge clk);
        #1;
        cur++;
      end
      link_up_in   = tab[i].lnk;
      act_pulse_in = tab[i].pulse;
      @(negedge clk);
      check($sformatf("blink@%0d", cur), {7'd0, blink}, {7'd0, tab[i].eb});
      check($sformatf("link@%0d", cur), link, tab[i].el);
      check($sformatf("act@%0d", cur), act, tab[i].ea);
      @(posedge clk);
      #1;
      act_pulse_in = 8'h00;
      cur++;
    end

    // ---- pulses ignored while every link is down ----
    link_up_in = 8'h00;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      act_pulse_in = 8'hFF;
      @(negedge clk);
      check($sformatf("act_linkdown_%0d", i), act, 8'hFF);
      check($sformatf("link_linkdown_%0d", i), link, 8'hFF);
      @(posedge clk);
      #1;
    end
    act_pulse_in = 8'h00;

    // ---- all links up, bounded wait for acceptance ----
    link_up_in = 8'hFF;
    wait_n = 0;
    while (link !== 8'h00 && wait_n < 24) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    check("link_all_up", link, 8'h00);
    check("act_after_linkup", act, 8'hFF);

    // ---- port independence and mid-stretch async reset ----
    act_pulse_in = 8'h08;
    @(posedge clk);
    #1 act_pulse_in = 8'h00;
    check("act_port3_only", act, 8'hF7);
    act_pulse_in = 8'hFF;
    @(posedge clk);
    #1 act_pulse_in = 8'h00;
    check("act_all_ports", act, 8'h00);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_blink", {7'd0, blink}, 8'h00);
    check("async_rst_link", link, 8'hFF);
    check("async_rst_act", act, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
